recomp_sched: RTL and testbench

Issue controller and two-requester arbiter for the mixed-radix recomposition chain. The chain has six cascaded ModMultAdd stages, and each stage feeds the next (moduli 65536 and 78125). The block accepts complete mixed-radix digit vectors from two requesters and skews the digits so that each one arrives at the same cycle as its stage's partial sum. It tracks in-flight operations through the fixed latency and buffers the normalized results in an output FIFO with valid/ready backpressure. The datapath cannot stall, so a credit check at issue time guarantees that the FIFO never overflows.

---
 rtl/recomp_sched.sv | 163 ++++++++++++++++
 tb/tb_recomp_sched.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/recomp_sched.sv
// recomp_sched: issue controller and two-requester round-robin arbiter for the
// six-stage mixed-radix recomposition chain.
//
// The winner's digit vector is skewed so slot i reaches the chain i*STAGE_LAT
// cycles after issue. This lines it up with that stage's partial sum. A track
// pipe follows each operation through the fixed chain latency. At the pipe exit,
// the chain result is captured into an output FIFO. The chain cannot stall, so
// an operation issues only when a FIFO slot is guaranteed free for it.
//
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   req{0,1}_valid/ready     requester handshake (ready only in the grant cycle)
//   req{0,1}_dig/cin/tag     operation digits, carry-in, opaque tag
//   pd_dig, pd_cin           skewed digits and carry-in to the chain
//   pd_norm0, pd_norm1       chain results, L cycles after issue
//   out_valid/ready          result FIFO handshake
//   out_norm0/1, src, tag    FIFO head contents
//   busy                     operation in flight or FIFO non-empty
module recomp_sched #(
    parameter int unsigned DW         = 18,
    parameter int unsigned NDIG       = 6,
    parameter int unsigned STAGE_LAT  = 3,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TAG_W      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [NDIG*DW-1:0]   req0_dig,
    input  logic                 req0_cin,
    input  logic [TAG_W-1:0]     req0_tag,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [NDIG*DW-1:0]   req1_dig,
    input  logic                 req1_cin,
    input  logic [TAG_W-1:0]     req1_tag,
    output logic [NDIG*DW-1:0]   pd_dig,
    output logic                 pd_cin,
    input  logic [DW-1:0]        pd_norm0,
    input  logic [DW-1:0]        pd_norm1,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_norm0,
    output logic [DW-1:0]        out_norm1,
    output logic                 out_src,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 busy
);
    localparam int unsigned L  = NDIG * STAGE_LAT;
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OW = $clog2(L + FIFO_DEPTH + 1);

    logic                 rr_q, rr_d;
    logic [L-1:0]         trk_v_q;
    logic [L-1:0]         trk_src_q;
    logic [TAG_W-1:0]     trk_tag_q [L];
    logic [DW-1:0]        fifo_n0_q [FIFO_DEPTH];
    logic [DW-1:0]        fifo_n1_q [FIFO_DEPTH];
    logic                 fifo_src_q [FIFO_DEPTH];
    logic [TAG_W-1:0]     fifo_tag_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [OW-1:0]        inflight, occupied;
    logic                 issue, win, push, pop;
    logic [NDIG*DW-1:0]   win_dig;
    logic                 win_cin;
    logic [TAG_W-1:0]     win_tag;

    // Occupancy counts slots already promised to in-flight operations. A pop
    // this cycle frees its slot only once cnt_q updates.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(L); i++) begin
            inflight = inflight + OW'(trk_v_q[i]);
        end
        occupied = OW'(cnt_q) + inflight;
    end

    always_comb begin
        win        = req1_valid && (!req0_valid || rr_q);
        issue      = !reset && (req0_valid || req1_valid) && (occupied < OW'(FIFO_DEPTH));
        req0_ready = issue && !win;
        req1_ready = issue && win;
        win_dig    = win ? req1_dig : req0_dig;
        win_cin    = win ? req1_cin : req0_cin;
        win_tag    = win ? req1_tag : req0_tag;
        // The pointer moves only when a real contest was resolved.
        rr_d       = (issue && req0_valid && req1_valid) ? !rr_q : rr_q;
    end

    // Slot 0 and carry-in meet the first stage in the issue cycle.
    assign pd_dig[DW-1:0] = issue ? win_dig[DW-1:0] : '0;
    assign pd_cin         = issue ? win_cin : 1'b0;

    for (genvar g = 1; g < int'(NDIG); g++) begin : g_skew
        localparam int unsigned D = g * STAGE_LAT;
        logic [DW-1:0] dl_q [D];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int k = 0; k < int'(D); k++) dl_q[k] <= '0;
            end else begin
                dl_q[0] <= issue ? win_dig[g*DW +: DW] : '0;
                for (int k = 1; k < int'(D); k++) dl_q[k] <= dl_q[k-1];
            end
        end

        assign pd_dig[g*DW +: DW] = dl_q[D-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q      <= 1'b0;
            trk_v_q   <= '0;
            trk_src_q <= '0;
            for (int i = 0; i < int'(L); i++) trk_tag_q[i] <= '0;
        end else begin
            rr_q      <= rr_d;
            trk_v_q   <= {trk_v_q[L-2:0], issue};
            trk_src_q <= {trk_src_q[L-2:0], win};
            trk_tag_q[0] <= win_tag;
            for (int i = 1; i < int'(L); i++) trk_tag_q[i] <= trk_tag_q[i-1];
        end
    end

    assign push  = trk_v_q[L-1];
    assign pop   = out_valid && out_ready;
    assign cnt_d = cnt_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_n0_q[i]  <= '0;
                fifo_n1_q[i]  <= '0;
                fifo_src_q[i] <= 1'b0;
                fifo_tag_q[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_n0_q[wr_ptr_q]  <= pd_norm0;
                fifo_n1_q[wr_ptr_q]  <= pd_norm1;
                fifo_src_q[wr_ptr_q] <= trk_src_q[L-1];
                fifo_tag_q[wr_ptr_q] <= trk_tag_q[L-1];
                wr_ptr_q             <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            cnt_q <= cnt_d;
        end
    end

    assign out_valid = (cnt_q != '0);
    assign out_norm0 = fifo_n0_q[rd_ptr_q];
    assign out_norm1 = fifo_n1_q[rd_ptr_q];
    assign out_src   = fifo_src_q[rd_ptr_q];
    assign out_tag   = fifo_tag_q[rd_ptr_q];
    assign busy      = out_valid || (|trk_v_q);

endmodule

// File: tb/tb_recomp_sched.sv
// tb_recomp_sched: randomized and directed bench for recomp_sched. It uses a
// queue-level model of issue, credit, round-robin, skew and FIFO behaviour, and
// a stand-in chain that rebuilds each operation from the skewed pd_dig stream.
module tb_recomp_sched;
    localparam int DW = 18, NDIG = 6, SL = 3, FD = 4, TW = 4, L = NDIG * SL;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                req0_valid = 1'b0, req1_valid = 1'b0;
    logic                req0_ready, req1_ready;
    logic [NDIG*DW-1:0]  req0_dig = '0, req1_dig = '0;
    logic                req0_cin = 1'b0, req1_cin = 1'b0;
    logic [TW-1:0]       req0_tag = '0, req1_tag = '0;
    logic [NDIG*DW-1:0]  pd_dig;
    logic                pd_cin;
    logic [DW-1:0]       pd_norm0 = '0, pd_norm1 = '0;
    logic                out_valid, out_ready = 1'b0;
    logic [DW-1:0]       out_norm0, out_norm1;
    logic                out_src, busy;
    logic [TW-1:0]       out_tag;

    int errors = 0, checks = 0, cyc = 0;
    logic got0 = 1'b0, got1 = 1'b0;

    recomp_sched dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_dig(req0_dig),
        .req0_cin(req0_cin), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_dig(req1_dig),
        .req1_cin(req1_cin), .req1_tag(req1_tag),
        .pd_dig(pd_dig), .pd_cin(pd_cin), .pd_norm0(pd_norm0), .pd_norm1(pd_norm1),
        .out_valid(out_valid), .out_ready(out_ready), .out_norm0(out_norm0),
        .out_norm1(out_norm1), .out_src(out_src), .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Stand-in chain arithmetic; any function of every digit and cin exposes skew errors.
    function automatic logic [DW-1:0] f0(input logic [NDIG*DW-1:0] d, input logic c);
        logic [DW-1:0] s;
        s = DW'(c);
        for (int i = 0; i < NDIG; i++) s = s + DW'((i + 1) * d[i*DW +: DW]);
        return s;
    endfunction

    function automatic logic [DW-1:0] f1(input logic [NDIG*DW-1:0] d, input logic c);
        logic [DW-1:0] x;
        x = '0;
        for (int i = 0; i < NDIG; i++) x = x ^ d[i*DW +: DW];
        return x + DW'(c);
    endfunction

    typedef struct {
        int                 cyc;
        logic               src;
        logic [TW-1:0]      tag;
        logic [NDIG*DW-1:0] dig;
        logic               cin;
    } op_t;
    typedef struct {
        logic [DW-1:0] n0, n1;
        logic          src;
        logic [TW-1:0] tag;
    } res_t;

    op_t  infl[$];
    res_t fifo[$];
    logic rr = 1'b0;
    logic [NDIG*DW-1:0] hist_dig [32];
    logic               hist_cin [32];

    // Model and compare: one sample per cycle, away from the rising edge.
    always @(negedge clk) begin
        int occ;
        logic g0, g1, exp_cin, c;
        logic [NDIG*DW-1:0] exp_dig, d;
        op_t op;
        res_t r;
        cyc++;
        hist_dig[cyc % 32] = pd_dig;
        hist_cin[cyc % 32] = pd_cin;
        got0 = req0_ready;
        got1 = req1_ready;
        if (reset) begin
            infl.delete();
            fifo.delete();
            rr = 1'b0;
            if (cyc > 2) begin
                chk("rst_ready", {req0_ready, req1_ready}, 0);
                chk("rst_pd", {pd_cin, pd_dig}, 0);
                chk("rst_out", {out_valid, busy, out_src, out_tag, out_norm0, out_norm1}, 0);
            end
        end else begin
            occ = infl.size() + fifo.size();
            g0 = (occ < FD) && req0_valid && (!req1_valid || rr == 1'b0);
            g1 = (occ < FD) && req1_valid && (!req0_valid || rr == 1'b1);
            chk("ready0", req0_ready, g0);
            chk("ready1", req1_ready, g1);
            exp_dig = '0;
            if (g0) exp_dig[DW-1:0] = req0_dig[DW-1:0];
            if (g1) exp_dig[DW-1:0] = req1_dig[DW-1:0];
            exp_cin = g0 ? req0_cin : (g1 ? req1_cin : 1'b0);
            foreach (infl[k])
                for (int i = 1; i < NDIG; i++)
                    if (infl[k].cyc == cyc - SL * i)
                        exp_dig[i*DW +: DW] = infl[k].dig[i*DW +: DW];
            chk("pd_dig", pd_dig, exp_dig);
            chk("pd_cin", pd_cin, exp_cin);
            chk("out_valid", out_valid, fifo.size() != 0);
            if (fifo.size() != 0)
                chk("out_head", {out_src, out_tag, out_norm0, out_norm1},
                    {fifo[0].src, fifo[0].tag, fifo[0].n0, fifo[0].n1});
            chk("busy", busy, occ != 0);
            if (fifo.size() != 0 && out_ready) void'(fifo.pop_front());
            if (infl.size() != 0 && infl[0].cyc == cyc - L) begin
                op = infl.pop_front();
                r.n0 = f0(op.dig, op.cin);
                r.n1 = f1(op.dig, op.cin);
                r.src = op.src;
                r.tag = op.tag;
                fifo.push_back(r);
            end
            if (g0 || g1) begin
                op.cyc = cyc;
                op.src = g1;
                op.tag = g1 ? req1_tag : req0_tag;
                op.dig = g1 ? req1_dig : req0_dig;
                op.cin = g1 ? req1_cin : req0_cin;
                infl.push_back(op);
                if (req0_valid && req1_valid) rr = ~rr;
            end
        end
        // Chain stand-in: reassemble the operation that entered L cycles ago.
        if (cyc >= L + 2) begin
            d = '0;
            for (int i = 0; i < NDIG; i++)
                d[i*DW +: DW] = hist_dig[(cyc - L + SL * i) % 32][i*DW +: DW];
            c = hist_cin[(cyc - L) % 32];
            pd_norm0 = f0(d, c);
            pd_norm1 = f1(d, c);
        end
    end

    function automatic logic [NDIG*DW-1:0] rnd_dig();
        logic [NDIG*DW-1:0] d;
        for (int i = 0; i < NDIG; i++) d[i*DW +: DW] = DW'($urandom);
        return d;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // A requester replaces its operation only after acceptance or while idle.
    task automatic refresh(input int pv0, input int pv1);
        if (got0 || !req0_valid) begin
            req0_valid = ($urandom_range(99) < pv0);
            req0_dig = rnd_dig();
            req0_cin = 1'($urandom);
            req0_tag = TW'($urandom);
        end
        if (got1 || !req1_valid) begin
            req1_valid = ($urandom_range(99) < pv1);
            req1_dig = rnd_dig();
            req1_cin = 1'($urandom);
            req1_tag = TW'($urandom);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (n < 200 && (req0_valid || req1_valid || busy)) begin
            step();
            refresh(0, 0);
            n++;
        end
        chk("drain_done", {req0_valid, req1_valid, busy}, 0);
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int cnt;
        logic [NDIG*DW-1:0] sk;
        // Reset with a pending request; deassert and expect an immediate issue.
        req0_valid = 1'b1; req0_dig = '0; req0_cin = 1'b1; req0_tag = 4'd5;
        repeat (4) step();
        chk("rst_ready_lit", {req0_ready, req1_ready}, 2'b00);
        chk("rst_out_lit", {out_valid, busy, pd_cin}, 3'b000);
        reset = 1'b0;
        #1;
        chk("first_issue", req0_ready, 1'b1);
        step();
        req0_valid = 1'b0;
        repeat (L - 1) step();
        chk("single_early", out_valid, 1'b0);
        step();
        chk("single_valid", out_valid, 1'b1);
        chk("single_head", {out_norm0, out_norm1, out_src, out_tag},
            {18'd1, 18'd1, 1'b0, 4'd5});
        out_ready = 1'b1;
        step();

        // Skew: slot i carries i+1 and must appear exactly i*SL cycles later.
        for (int i = 0; i < NDIG; i++) sk[i*DW +: DW] = DW'(i + 1);
        req0_dig = sk; req0_cin = 1'b1; req0_tag = 4'd3; req0_valid = 1'b1;
        #1;
        chk("skew_ready", req0_ready, 1'b1);
        for (int k = 0; k < L; k++) begin
            for (int i = 0; i < NDIG; i++)
                chk("skew_slot", pd_dig[i*DW +: DW], (k == SL * i) ? DW'(i + 1) : DW'(0));
            chk("skew_cin", pd_cin, k == 0);
            step();
            req0_valid = 1'b0;
            #1;
        end
        drain();

        // Both requesters continuously valid: grants alternate starting at 0.
        refresh(100, 100);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("alt_grant", {req0_ready, req1_ready}, (k % 2 == 0) ? 2'b10 : 2'b01);
            step();
            refresh(100, 100);
            #1;
        end
        repeat (L - 3) step();
        for (int k = 0; k < 4; k++) begin
            chk("alt_result", {out_valid, out_src}, {1'b1, 1'((k % 2))});
            step();
            refresh(100, 100);
        end
        drain();

        // Consumer stalled: exactly FD issues, then nothing until a pop.
        out_ready = 1'b0;
        cnt = 0;
        refresh(100, 100);
        for (int k = 0; k < 30; k++) begin
            #1;
            cnt += int'(req0_ready) + int'(req1_ready);
            step();
            refresh(100, 100);
        end
        chk("stall_issues", cnt, 4);
        chk("stall_full", out_valid, 1'b1);
        out_ready = 1'b1;
        #1;
        chk("pop_cycle_no_issue", {req0_ready, req1_ready}, 2'b00);
        step();
        out_ready = 1'b0;
        refresh(100, 100);
        #1;
        chk("pop_reissue", int'(req0_ready) + int'(req1_ready), 1);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            refresh(100, 100);
            #1;
            cnt += int'(req0_ready) + int'(req1_ready);
        end
        chk("stall_again", cnt, 0);
        drain();

        // Random traffic and backpressure.
        for (int k = 0; k < 3000; k++) begin
            refresh(k < 1500 ? 30 : 80, k < 1500 ? 60 : 80);
            out_ready = ($urandom_range(99) < ((k % 600) < 300 ? 80 : 25));
            step();
        end
        drain();

        // Reset five cycles after three issues, with a request pending.
        for (int k = 0; k < 3; k++) begin
            req0_valid = 1'b1; req0_dig = rnd_dig(); req0_tag = TW'(k);
            #1;
            chk("pre_rst_issue", req0_ready, 1'b1);
            step();
        end
        req0_valid = 1'b0;
        repeat (5) step();
        req0_valid = 1'b1; req0_dig = rnd_dig(); req0_cin = 1'b1; req0_tag = 4'd9;
        #1;
        reset = 1'b1;
        #1;
        chk("rst_async_pd", {pd_cin, pd_dig}, 0);
        chk("rst_async_out", {out_valid, busy, req0_ready, req1_ready}, 4'b0000);
        step();
        step();
        reset = 1'b0;
        #1;
        chk("post_rst_issue", req0_ready, 1'b1);
        step();
        req0_valid = 1'b0;
        cnt = 0;
        out_ready = 1'b1;
        for (int k = 0; k < L + 10; k++) begin
            cnt += int'(out_valid);
            step();
        end
        chk("post_rst_results", cnt, 1);
        chk("post_rst_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
